mem_port_arbiter: RTL

Round-robin arbiter and sequencer that shares one single-ported memory interface among four requesters. Candidates are instruction fetch, data load/store, a debug port and a DMA port. The block picks one requester and drives the 2-bit select of the address/write-data 4-way muxes in the pipeline's memory stage. It holds the grant until the memory acknowledges or a timeout fires, then returns read data with a one-cycle done pulse.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_pick4.sv | 30 +++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, requester count
// and a one-hot helper for grant/done vectors.
package mem_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational circular priority picker: first set req bit at or after ptr,
// wrapping around the four requesters.
module rr_pick4
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a path that
    // never assigns it would infer a latch.
    idx  = ptr;
    any  = 1'b0;
    cand = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer sharing one single-ported memory among four requesters;
// holds the grant until mem_ready or timeout, then pulses done with read data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*WIDTH-1:0] addr_i,
  input  logic [NREQ*WIDTH-1:0] wdata_i,
  input  logic                  mem_ready,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [SEL_W-1:0]      sel,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [WIDTH-1:0]      rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state, state_next;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic [CNT_W-1:0] wait_cnt;
  logic             we_q;
  logic             err_q;
  logic             timeout_hit;
  logic [WIDTH-1:0] addr_pick;
  logic [WIDTH-1:0] wdata_pick;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign addr_pick   = addr_i[int'(pick_idx)*WIDTH +: WIDTH];
  assign wdata_pick  = wdata_i[int'(pick_idx)*WIDTH +: WIDTH];
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    gnt        = '0;
    done       = '0;
    err        = 1'b0;
    case (state)
      IDLE: if (pick_any) state_next = BUSY;
      BUSY: begin
        mem_en = 1'b1;
        mem_we = we_q;
        gnt    = onehot(sel);
        if (mem_ready || timeout_hit) state_next = RESP;
      end
      RESP: begin
        done       = onehot(sel);
        err        = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request side is sampled only in IDLE, so the captured access stays frozen
  // for the rest of the transaction whatever the requester does meanwhile.
  always_ff @(posedge clk) begin
    // NOTE: registered state is always assigned with <= so every flop sees the
    // pre-edge values of its neighbours, independent of statement order.
    if (rst) begin
      ptr       <= '0;
      sel       <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      wait_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          sel       <= pick_idx;
          we_q      <= we[pick_idx];
          mem_addr  <= addr_pick;
          mem_wdata <= wdata_pick;
          wait_cnt  <= '0;
        end
        BUSY: begin
          if (mem_ready) begin
            rdata <= mem_rdata;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            rdata <= '0;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: ptr <= sel + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
